trig_burst_capture: RTL and testbench
=====================================

Name: trig_burst_capture

Overview:
- Downstream of the quarter-period-delay trigger stage, in the `sclock` domain.
- Once armed, a one-cycle `trigger` pulse starts capture of a burst of ADC samples into an on-chip buffer.
- The buffer is then drained over a valid/ready stream to the readout path that feeds the C server.
- The block never corrupts a burst: a trigger that arrives while busy is dropped and flagged.

Parameters:
- SAMPLE_W, 14: ADC sample width in bits.
- ADDR_W, 8: buffer address width; buffer depth = 2**ADDR_W samples.
- CNT_W, 16: width of the completed-burst counter.

Ports:
- sclock  in  1  sample clock; every register is in this domain.
- reset  in  1  synchronous, active-high reset.
- arm  in  1  single-cycle request to accept the next trigger.
- burst_len  in  ADDR_W+1  samples per burst; sampled on `arm`; 0 or >2**ADDR_W clamps to 2**ADDR_W.
- trigger  in  1  one-cycle pulse from the delay stage.
- adc_data  in  SAMPLE_W  ADC sample.
- adc_valid  in  1  `adc_data` is valid this cycle.
- m_data  out  SAMPLE_W  drained sample.
- m_valid  out  1  `m_data` is valid.
- m_ready  in  1  consumer accepts `m_data`.
- m_last  out  1  marks the final sample of a burst, qualified by `m_valid`.
- busy  out  1  high in ARMED, CAPTURE and DRAIN.
- overrun  out  1  sticky: a trigger arrived in CAPTURE or DRAIN.
- burst_count  out  CNT_W  number of bursts fully drained.

Behaviour:
- Reset (also asserted mid-burst):
  - state goes to IDLE.
  - `m_valid`, `m_last`, `busy` and `overrun` go to 0; `burst_count` goes to 0.
  - Buffer contents are not cleared; any partial burst is discarded.
- State IDLE:
  - `arm` -> ARMED next cycle; latch the clamped `burst_len` into `len_q`.
  - `trigger` in IDLE, including the same cycle as `arm`, is ignored and is not an overrun.
- State ARMED:
  - `trigger` -> CAPTURE next cycle; write pointer `wr_ptr` = 0.
  - `arm` while ARMED re-latches `burst_len`.
- State CAPTURE:
  - Each cycle with `adc_valid` writes `adc_data` to `buf[wr_ptr]` and increments `wr_ptr`.
  - The sample present in the trigger cycle itself is not captured.
  - When the write brings `wr_ptr` to `len_q`: go to DRAIN next cycle.
  - `adc_valid` gaps stall capture; there is no timeout.
- State DRAIN:
  - Read pointer starts at 0; the buffer read is 1-cycle synchronous, behind a one-entry output register.
  - `m_valid` rises no later than 2 cycles after DRAIN entry.
  - `m_data` and `m_last` hold stable while `m_valid && !m_ready`.
  - Each `m_valid && m_ready` handshake advances to the next sample. With `m_ready` held at 1, sustained throughput is 1 sample per cycle after the first.
  - `m_last` is high only with sample index `len_q`-1.
  - Handshake on the last sample: next cycle state goes to IDLE and `burst_count` increments; it wraps modulo 2**CNT_W with no saturation.
- Triggers and `arm` outside IDLE/ARMED:
  - `trigger` in CAPTURE or DRAIN sets `overrun` (cleared only by reset) and is otherwise ignored.
  - `arm` in CAPTURE or DRAIN is ignored.
- Simultaneous events:
  - `trigger` and `adc_valid` in the same ARMED cycle: the sample is not captured.
  - Final write and `trigger` in the same cycle: `overrun` is set.
- Width rules: `wr_ptr` and `rd_ptr` are ADDR_W+1 bits so a full-depth burst terminates without aliasing. Compare against `len_q`, never against a wrapped pointer.

Decomposition:
- Package `capture_pkg`:
  - state enum {IDLE, ARMED, CAPTURE, DRAIN}.
  - function clamping `burst_len`.
  - localparam for default depth.
- Sub-module `sample_buffer_ram`: simple dual-port RAM, one write port and one registered read port, parameterised by SAMPLE_W and ADDR_W, inferable as block RAM.
- FSM, pointers and output register stay in the top module.

Test Plan:
1. `reset`, `arm` with `burst_len`=4, `trigger`, then `adc_valid` high with `adc_data` 10,11,12,13, `m_ready`=1 -> stream 10,11,12,13, `m_last` on 13, `burst_count`=1, state IDLE.
2. `arm` with `burst_len`=0, ADDR_W=8 -> 256 samples captured; `m_last` on the 256th; no early termination at pointer wrap.
3. `trigger` pulse in IDLE, and `trigger` in the same cycle as `arm` -> no capture, `busy` shows only ARMED, `overrun`=0.
4. Second `trigger` during CAPTURE and another during DRAIN -> `overrun`=1 and sticky, burst data unchanged, `burst_count`=1.
5. `burst_len`=3, `m_ready` toggling 1,0,0,1,0,1 -> `m_data` and `m_last` stable during stalls; exactly 3 handshakes; `adc_valid` gaps in CAPTURE only delay completion.
6. `reset` asserted mid-DRAIN after 2 of 5 samples -> next cycle `m_valid`=0, `busy`=0, `overrun`=0, `burst_count`=0. A new `arm`/`trigger` then captures a fresh full burst.

Source files
------------

// File: rtl/trig_burst_capture_pkg.sv
// Shared types and helpers for the triggered burst capture block.
package capture_pkg;

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDrain} state_e;

  localparam int unsigned DefaultAddrW = 8;
  localparam int unsigned DefaultDepth = 32'd1 << DefaultAddrW;

  // Zero or oversize requests mean "fill the whole buffer".
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned addr_w);
    int unsigned depth;
    depth = 32'd1 << addr_w;
    return ((len == 0) || (len > depth)) ? depth : len;
  endfunction

endpackage

// File: rtl/trig_burst_capture_if.sv
// Valid/ready drain stream carrying captured samples and the end-of-burst marker.
interface trig_burst_capture_if #(
  parameter int unsigned SAMPLE_W = 14
);
  logic [SAMPLE_W-1:0] m_data;
  logic                m_valid;
  logic                m_ready;
  logic                m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/sample_buffer_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module sample_buffer_ram #(
  parameter int unsigned SAMPLE_W = 14,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [SAMPLE_W-1:0] wdata_i,
  input  logic                re_i,
  input  logic [ADDR_W-1:0]   raddr_i,
  output logic [SAMPLE_W-1:0] rdata_o
);

  logic [SAMPLE_W-1:0] mem_q [2**ADDR_W];
  logic [SAMPLE_W-1:0] rdata_q;

  // Read data holds when re_i is low so a stalled drain keeps its fetched sample.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/trig_burst_capture.sv
// Arm/trigger burst capture into an on-chip buffer, then drain over a valid/ready stream.
module trig_burst_capture
  import capture_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 14,
  parameter int unsigned ADDR_W   = DefaultAddrW,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                sclock,
  input  logic                reset,
  input  logic                arm,
  input  logic [ADDR_W:0]     burst_len,
  input  logic                trigger,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                adc_valid,
  trig_burst_capture_if.master m_if,
  output logic                busy,
  output logic                overrun,
  output logic [CNT_W-1:0]    burst_count
);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                pend_q, pend_d, mv_q, mv_d, ml_q, ml_d, ovr_q, ovr_d;
  logic [SAMPLE_W-1:0] md_q, md_d, rd_data;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we, rd_en, hs, load;
  int unsigned         clamp_full;
  logic [ADDR_W:0]     len_clamped, wr_ptr_nxt;

  assign clamp_full  = clamp_len(32'(burst_len), ADDR_W);
  assign len_clamped = clamp_full[ADDR_W:0];
  assign wr_ptr_nxt  = wr_ptr_q + 1'b1;
  assign hs          = mv_q && m_if.m_ready;
  // pend_q: a RAM read was issued last cycle and its data sits on rd_data.
  assign load        = pend_q && (!mv_q || hs);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pend_d   = pend_q;
    mv_d     = mv_q;
    ml_d     = ml_q;
    md_d     = md_q;
    ovr_d    = ovr_q;
    cnt_d    = cnt_q;
    we       = 1'b0;
    rd_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arm) begin
          len_d   = len_clamped;
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (arm) len_d = len_clamped;
        if (trigger) begin
          wr_ptr_d = '0;
          state_d  = StCapture;
        end
      end
      StCapture: begin
        if (trigger) ovr_d = 1'b1;
        if (adc_valid) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_nxt;
          if (wr_ptr_nxt == len_q) begin
            rd_ptr_d = '0;
            pend_d   = 1'b0;
            mv_d     = 1'b0;
            ml_d     = 1'b0;
            state_d  = StDrain;
          end
        end
      end
      StDrain: begin
        if (trigger) ovr_d = 1'b1;
        if (hs) begin
          mv_d = 1'b0;
          ml_d = 1'b0;
        end
        if (load) begin
          mv_d   = 1'b1;
          md_d   = rd_data;
          ml_d   = (rd_ptr_q == len_q);
          pend_d = 1'b0;
        end
        if ((!pend_q || load) && (rd_ptr_q < len_q)) begin
          rd_en    = 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
          pend_d   = 1'b1;
        end
        if (hs && ml_q) begin
          mv_d    = 1'b0;
          ml_d    = 1'b0;
          pend_d  = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sclock) begin
    if (reset) begin
      state_q  <= StIdle;
      len_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pend_q   <= 1'b0;
      mv_q     <= 1'b0;
      ml_q     <= 1'b0;
      md_q     <= '0;
      ovr_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pend_q   <= pend_d;
      mv_q     <= mv_d;
      ml_q     <= ml_d;
      md_q     <= md_d;
      ovr_q    <= ovr_d;
      cnt_q    <= cnt_d;
    end
  end

  sample_buffer_ram #(
    .SAMPLE_W (SAMPLE_W),
    .ADDR_W   (ADDR_W)
  ) u_buf (
    .clk_i   (sclock),
    .we_i    (we),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (adc_data),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rd_data)
  );

  assign m_if.m_data  = md_q;
  assign m_if.m_valid = mv_q;
  assign m_if.m_last  = ml_q;
  assign busy         = (state_q != StIdle);
  assign overrun      = ovr_q;
  assign burst_count  = cnt_q;

endmodule

// File: tb/tb_trig_burst_capture.sv
// Randomized directed bench for trig_burst_capture with a queue-based reference model.
module tb_trig_burst_capture;

  localparam int SW = 14;
  localparam int AW = 8;
  localparam int CW = 16;

  logic          sclock = 1'b0;
  logic          reset, arm, trigger, adc_valid;
  logic [AW:0]   burst_len;
  logic [SW-1:0] adc_data;
  logic          busy, overrun;
  logic [CW-1:0] burst_count;

  trig_burst_capture_if #(.SAMPLE_W(SW)) m_if ();

  trig_burst_capture #(
    .SAMPLE_W (SW),
    .ADDR_W   (AW),
    .CNT_W    (CW)
  ) dut (
    .sclock      (sclock),
    .reset       (reset),
    .arm         (arm),
    .burst_len   (burst_len),
    .trigger     (trigger),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .m_if        (m_if),
    .busy        (busy),
    .overrun     (overrun),
    .burst_count (burst_count)
  );

  always #5 sclock = ~sclock;

  int            total = 0;
  int            bad = 0;
  int            cnt_m = 0;
  bit            ovr_m = 1'b0;
  logic [SW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; arm = 1'b0; trigger = 1'b0; adc_valid = 1'b0; m_if.m_ready = 1'b0;
    @(negedge sclock);
    reset = 1'b0;
    cnt_m = 0;
    ovr_m = 1'b0;
  endtask

  task automatic do_arm(input int len);
    arm = 1'b1;
    burst_len = len[AW:0];
    @(negedge sclock);
    arm = 1'b0;
  endtask

  // Trigger cycle also presents a valid sample that must not be captured.
  task automatic do_trigger();
    trigger = 1'b1; adc_valid = 1'b1; adc_data = SW'($urandom);
    @(negedge sclock);
    trigger = 1'b0; adc_valid = 1'b0;
  endtask

  // trig_at >= 0: extra trigger on that cycle; -2: trigger on the final write.
  task automatic do_capture(input int n, input int gap_pct, input int trig_at);
    int  k = 0;
    bit  v;
    exp_q.delete();
    while (exp_q.size() < n) begin
      v = ($urandom_range(99) >= gap_pct);
      adc_valid = v;
      adc_data = SW'($urandom);
      if (v) exp_q.push_back(adc_data);
      trigger = (k == trig_at) || (trig_at == -2 && v && exp_q.size() == n);
      if (trigger) ovr_m = 1'b1;
      k++;
      @(negedge sclock);
    end
    adc_valid = 1'b0;
    trigger = 1'b0;
  endtask

  task automatic do_drain(input int ready_mode, input bit disturb, input int stop_after);
    int            idx = 0;
    int            cyc_n = 0;
    int            first = -1;
    int            n = exp_q.size();
    int            budget = 4 * n + 20;
    bit            pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic          pv = 1'b0, pr = 1'b0, pl = 1'b0, r;
    logic [SW-1:0] pd = '0;
    while (idx < n && idx != stop_after && cyc_n < budget) begin
      if (pv && !pr) begin
        chk("stall_data", 32'(m_if.m_data), 32'(pd));
        chk("stall_last", 32'(m_if.m_last), 32'(pl));
      end
      if (m_if.m_valid && first < 0) first = cyc_n;
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = pat[cyc_n % 6];
        default: r = 1'(($urandom_range(1)));
      endcase
      m_if.m_ready = r;
      trigger = disturb && (cyc_n == 1);
      arm = disturb && (cyc_n == 1);
      if (trigger) begin
        ovr_m = 1'b1;
        burst_len = 9'd1;
      end
      if (m_if.m_valid && r) begin
        chk("drain_data", 32'(m_if.m_data), 32'(exp_q[idx]));
        chk("drain_last", 32'(m_if.m_last), 32'(idx == n - 1));
        idx++;
      end
      pv = m_if.m_valid; pr = r; pd = m_if.m_data; pl = m_if.m_last;
      cyc_n++;
      @(negedge sclock);
    end
    trigger = 1'b0; arm = 1'b0; m_if.m_ready = 1'b0;
    chk("first_valid_by_2", 32'(first >= 0 && first <= 2), 32'd1);
    if (stop_after < 0) chk("drain_count", idx, n);
    if (idx == n) cnt_m++;
  endtask

  task automatic post(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(m_if.m_valid), 32'd0);
    chk({tag, "_count"}, 32'(burst_count), 32'(cnt_m % (1 << CW)));
    chk({tag, "_overrun"}, 32'(overrun), 32'(ovr_m));
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; trigger = 1'b0; adc_valid = 1'b0;
    burst_len = '0; adc_data = '0; m_if.m_ready = 1'b0;
    @(negedge sclock);
    do_reset();
    post("reset");
    chk("reset_last", 32'(m_if.m_last), 32'd0);

    // Directed 4-sample burst 10..13.
    do_arm(4);
    chk("t1_armed_busy", 32'(busy), 32'd1);
    do_trigger();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      adc_valid = 1'b1;
      adc_data = SW'(10 + i);
      exp_q.push_back(adc_data);
      @(negedge sclock);
    end
    adc_valid = 1'b0;
    do_drain(0, 1'b0, -1);
    post("t1");

    // Full-depth bursts: length 0 and oversize both clamp to 256.
    do_arm(0);
    do_trigger();
    do_capture(256, 0, -1);
    do_drain(0, 1'b0, -1);
    post("t2_len0");
    do_arm(300);
    do_trigger();
    do_capture(256, 20, -1);
    do_drain(2, 1'b0, -1);
    post("t2_len300");

    // Triggers in IDLE are ignored; arm+trigger together only arms.
    trigger = 1'b1;
    @(negedge sclock);
    trigger = 1'b0;
    chk("t3_idle_trig_busy", 32'(busy), 32'd0);
    chk("t3_idle_trig_ovr", 32'(overrun), 32'd0);
    arm = 1'b1; trigger = 1'b1; burst_len = 9'd2;
    @(negedge sclock);
    arm = 1'b0; trigger = 1'b0;
    for (int i = 0; i < 5; i++) begin
      adc_valid = 1'b1;
      adc_data = SW'($urandom);
      @(negedge sclock);
      chk("t3_armed_busy", 32'(busy), 32'd1);
      chk("t3_armed_novalid", 32'(m_if.m_valid), 32'd0);
    end
    adc_valid = 1'b0;
    chk("t3_ovr", 32'(overrun), 32'd0);
    do_arm(7);
    do_arm(3);
    do_trigger();
    do_capture(3, 30, -1);
    do_drain(2, 1'b0, -1);
    post("t3");

    // Overrun from triggers during CAPTURE and DRAIN; arm in DRAIN ignored.
    do_reset();
    do_arm(6);
    do_trigger();
    do_capture(6, 25, 1);
    chk("t4_ovr_capture", 32'(overrun), 32'd1);
    do_drain(2, 1'b1, -1);
    post("t4");
    do_arm(2);
    do_trigger();
    do_capture(2, 0, -1);
    do_drain(0, 1'b0, -1);
    post("t4_sticky");

    // Stalling consumer, capture gaps, trigger on the final write.
    do_reset();
    do_arm(3);
    do_trigger();
    do_capture(3, 40, -2);
    do_drain(1, 1'b0, -1);
    post("t5");

    // Reset mid-drain, then a fresh burst.
    do_reset();
    do_arm(5);
    do_trigger();
    do_capture(5, 0, -1);
    do_drain(0, 1'b0, 2);
    reset = 1'b1;
    @(negedge sclock);
    reset = 1'b0;
    cnt_m = 0;
    ovr_m = 1'b0;
    post("t6_reset");
    do_arm(5);
    do_trigger();
    do_capture(5, 30, -1);
    do_drain(2, 1'b0, -1);
    post("t6_fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
